// File: rtl/apb_uart_rx.sv
// apb_uart_rx: APB slave UART receiver with 16x oversampling, 8N1 deframing,
// a small receive FIFO and RXDATA / STATUS / CTRL registers.
// Optional build macro RX_PARITY_EN switches the frame to 8E1 and enables the
// PE sticky flag (STATUS bit4).
module apb_uart_rx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  uart_rx,
  output logic                  rx_irq
);

  localparam int unsigned DIV   = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state;
  logic             rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tc;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             parity_bad;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ctrl_en, ctrl_irq_en;
  logic             fe, ovr, pe;

  logic        access_c, rd_c, wr_c;
  logic [1:0]  addr_c;
  logic        empty_c, full_c, pop_c, tick_c;
  logic        stop_evt_c, stop_ok_c, push_c, ovr_set_c, fe_set_c, pe_set_c;
  logic        sts_wr_c;
  logic [11:0] status_c;
  logic        unused_bits;

  assign PREADY   = 1'b1;
  assign access_c = PSEL & PENABLE;
  assign rd_c     = access_c & ~PWRITE;
  assign wr_c     = access_c & PWRITE;
  assign addr_c   = PADDR[3:2];
  assign sts_wr_c = wr_c & (addr_c == 2'd1);

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(FIFO_DEPTH));
  assign pop_c   = rd_c & (addr_c == 2'd0) & ~empty_c;
  assign tick_c  = (state != S_IDLE) & (div_cnt == DIV_W'(DIV - 1));

  // Stop-bit sampling outcome: push, overrun or framing error
  assign stop_evt_c = ctrl_en & (state == S_STOP) & tick_c & (tc == 4'd15);
  assign stop_ok_c  = stop_evt_c & rx_sync;
  assign push_c     = stop_ok_c & ~parity_bad & (~full_c | pop_c);
  assign ovr_set_c  = stop_ok_c & ~parity_bad & full_c & ~pop_c;
  assign fe_set_c   = stop_evt_c & ~rx_sync;

  assign status_c = {4'(count), 3'b000, pe, ovr, fe, full_c, ~empty_c};

`ifdef RX_PARITY_EN
  assign pe_set_c    = ctrl_en & (state == S_PARITY) & tick_c & (tc == 4'd15)
                       & (rx_sync ^ (^shreg));
  assign unused_bits = ^{PADDR[ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[DATA_WIDTH-1:5]};
`else
  assign pe_set_c    = 1'b0;
  assign parity_bad  = 1'b0;
  assign pe          = 1'b0;
  assign unused_bits = ^{PADDR[ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[DATA_WIDTH-1:4], pe_set_c};
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detect
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Oversample tick divider, parked at zero while idle
  always_ff @(posedge CLK) begin
    if (RST || state == S_IDLE || tick_c) div_cnt <= '0;
    else                                  div_cnt <= div_cnt + DIV_W'(1);
  end

  // Receive FSM: start validation, data shift, optional parity, stop check
  always_ff @(posedge CLK) begin
    if (RST || !ctrl_en) begin
      state   <= S_IDLE;
      tc      <= 4'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
`ifdef RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          tc      <= 4'd0;
          bit_idx <= 3'd0;
`ifdef RX_PARITY_EN
          parity_bad <= 1'b0;
`endif
          if (rx_prev && !rx_sync) state <= S_START;
        end
        S_START: if (tick_c) begin
          if (tc == 4'd7) begin
            tc    <= 4'd0;
            state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            tc <= tc + 4'd1;
          end
        end
        S_DATA: if (tick_c) begin
          tc <= tc + 4'd1;
          if (tc == 4'd15) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
        S_PARITY: if (tick_c) begin
          tc <= tc + 4'd1;
          if (tc == 4'd15) begin
`ifdef RX_PARITY_EN
            parity_bad <= rx_sync ^ (^shreg);
`endif
            state <= S_STOP;
          end
        end
        S_STOP: if (tick_c) begin
          tc <= tc + 4'd1;
          if (tc == 4'd15) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (push_c) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      count <= count + CNT_W'(1);
      else if (pop_c && !push_c) count <= count - CNT_W'(1);
    end
  end

  // Control register, sticky flags (set beats W1C) and interrupt
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_en     <= 1'b1;
      ctrl_irq_en <= 1'b0;
      fe          <= 1'b0;
      ovr         <= 1'b0;
      rx_irq      <= 1'b0;
    end else begin
      if (wr_c && addr_c == 2'd2) begin
        ctrl_en     <= PWDATA[0];
        ctrl_irq_en <= PWDATA[1];
      end
      fe     <= fe_set_c  | (fe  & ~(sts_wr_c & PWDATA[2]));
      ovr    <= ovr_set_c | (ovr & ~(sts_wr_c & PWDATA[3]));
      rx_irq <= ctrl_irq_en & (~empty_c | fe | ovr | pe);
    end
  end

`ifdef RX_PARITY_EN
  // Parity error sticky flag
  always_ff @(posedge CLK) begin
    if (RST) pe <= 1'b0;
    else     pe <= pe_set_c | (pe & ~(sts_wr_c & PWDATA[4]));
  end
`endif

  // Combinational read data and error response
  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access_c) begin
      unique case (addr_c)
        2'd0: begin
          if (PWRITE || empty_c) PSLVERR = 1'b1;
          else                   PRDATA  = DATA_WIDTH'(mem[rd_ptr]);
        end
        2'd1: if (!PWRITE) PRDATA = DATA_WIDTH'(status_c);
        2'd2: if (!PWRITE) PRDATA = DATA_WIDTH'({ctrl_irq_en, ctrl_en});
        default: PSLVERR = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_rx.sv
// Self-checking bench for apb_uart_rx: directed plan steps followed by a
// randomized frame/read/status mix checked against a queue-based model.
module tb_apb_uart_rx;

  localparam int unsigned BIT_CLKS = 64;
  localparam logic [31:0] A_RX = 32'h0, A_ST = 32'h4, A_CT = 32'h8, A_RS = 32'hC;

  logic        CLK, RST, PSEL, PENABLE, PWRITE, uart_rx;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, rx_irq;

  int n_tests, n_fail;

  logic [7:0] model_q[$];
  logic       m_fe, m_ovr, m_pe;

  apb_uart_rx #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .CLOCK_RATE(6400000), .BAUD_RATE(100000), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .uart_rx(uart_rx), .rx_irq(rx_irq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: what one received frame does to FIFO and flags
  function automatic void model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    if (!par_ok) m_pe = 1'b1;
    if (!stop_ok) m_fe = 1'b1;
    else if (par_ok) begin
      if (model_q.size() == 4) m_ovr = 1'b1;
      else model_q.push_back(b);
    end
  endfunction

  function automatic logic [31:0] model_status();
    logic [3:0] n;
    n = 4'(model_q.size());
    return {20'd0, n, 3'd0, m_pe, m_ovr, m_fe, (n == 4'd4), (n != 4'd0)};
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge CLK); #1 PENABLE = 1'b1;
    #1 d = PRDATA; e = PSLVERR;
    @(posedge CLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] v, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = v;
    @(posedge CLK); #1 PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(posedge CLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Drive one serial frame; par_ok=0 inverts the even-parity bit when present
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    uart_rx = 1'b0; clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i]; clks(BIT_CLKS);
    end
`ifdef RX_PARITY_EN
    uart_rx = (^b) ^ ~par_ok; clks(BIT_CLKS);
`endif
    uart_rx = stop_ok; clks(BIT_CLKS);
    uart_rx = 1'b1; clks(10);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    send_frame(b, stop_ok, par_ok);
    model_frame(b, stop_ok, par_ok);
  endtask

  task automatic check_rxdata(input string tag);
    logic [31:0] d, exp_d;
    logic        e, exp_e;
    if (model_q.size() == 0) begin
      exp_d = 32'd0; exp_e = 1'b1;
    end else begin
      exp_d = 32'(model_q.pop_front()); exp_e = 1'b0;
    end
    apb_rd(A_RX, d, e);
    chk({tag, ".data"}, d, exp_d);
    chk({tag, ".err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    logic        e;
    apb_rd(A_ST, d, e);
    chk(tag, d, model_status());
  endtask

  task automatic w1c_status(input logic [31:0] v);
    logic e;
    apb_wr(A_ST, v, e);
    if (v[2]) m_fe = 1'b0;
    if (v[3]) m_ovr = 1'b0;
`ifdef RX_PARITY_EN
    if (v[4]) m_pe = 1'b0;
`endif
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [7:0]  b;
    int          r;
    CLK = 1'b0; RST = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; uart_rx = 1'b1;
    n_tests = 0; n_fail = 0;
    m_fe = 1'b0; m_ovr = 1'b0; m_pe = 1'b0;
    clks(3);
    RST = 1'b0;

    // Reset state
    chk("rst.prdata", PRDATA, 32'd0);
    chk("rst.pslverr", 32'(PSLVERR), 32'd0);
    chk("rst.irq", 32'(rx_irq), 32'd0);
    chk("rst.pready", 32'(PREADY), 32'd1);
    apb_rd(A_ST, d, e); chk("rst.status", d, 32'h000);
    apb_rd(A_CT, d, e); chk("rst.ctrl", d, 32'h1);

    // 1: single byte
    rx_frame(8'hA5, 1'b1, 1'b1);
    apb_rd(A_ST, d, e); chk("t1.status", d, 32'h101);
    chk("t1.irq", 32'(rx_irq), 32'd0);
    apb_rd(A_RX, d, e); chk("t1.data", d, 32'hA5); chk("t1.err", 32'(e), 32'd0);
    void'(model_q.pop_front());
    apb_rd(A_ST, d, e); chk("t1.status2", d, 32'h000);

    // 2: overrun
    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1, 1'b1);
    apb_rd(A_ST, d, e); chk("t2.status", d, 32'h40B);
    for (int i = 1; i <= 4; i++) check_rxdata("t2.rd");
    apb_rd(A_RX, d, e); chk("t2.rd5.err", 32'(e), 32'd1); chk("t2.rd5.data", d, 32'd0);
    w1c_status(32'h8);
    apb_rd(A_ST, d, e); chk("t2.ovr_clr", d, 32'h000);

    // 3: framing error
    rx_frame(8'h3C, 1'b0, 1'b1);
    apb_rd(A_ST, d, e); chk("t3.status", d, 32'h004);
    apb_rd(A_RX, d, e); chk("t3.err", 32'(e), 32'd1); chk("t3.data", d, 32'd0);
    w1c_status(32'h4);
    check_status("t3.fe_clr");

    // 4: glitch shorter than half a bit
    uart_rx = 1'b0; clks(20); uart_rx = 1'b1; clks(700);
    apb_rd(A_ST, d, e); chk("t4.status", d, 32'h000);
    rx_frame(8'h55, 1'b1, 1'b1);
    check_rxdata("t4.rd");

    // 5: interrupt, then reset mid-frame
    apb_wr(A_CT, 32'h3, e);
    chk("t5.irq_idle", 32'(rx_irq), 32'd0);
    rx_frame(8'h7E, 1'b1, 1'b1);
    chk("t5.irq_set", 32'(rx_irq), 32'd1);
    check_rxdata("t5.rd");
    chk("t5.irq_hold", 32'(rx_irq), 32'd1);
    clks(1);
    chk("t5.irq_fall", 32'(rx_irq), 32'd0);
    uart_rx = 1'b0; clks(BIT_CLKS);
    uart_rx = 1'b1; clks(BIT_CLKS);
    uart_rx = 1'b0; clks(BIT_CLKS);
    RST = 1'b1; clks(1);
    RST = 1'b0; uart_rx = 1'b1;
    model_q.delete(); m_fe = 1'b0; m_ovr = 1'b0; m_pe = 1'b0;
    clks(700);
    apb_rd(A_ST, d, e); chk("t5.rst_status", d, 32'h000);
    apb_rd(A_CT, d, e); chk("t5.rst_ctrl", d, 32'h1);
    chk("t5.rst_irq", 32'(rx_irq), 32'd0);

    // 6: error responses and address aliasing
    apb_rd(A_RS, d, e); chk("t6.rsv_rd.err", 32'(e), 32'd1); chk("t6.rsv_rd.data", d, 32'd0);
    apb_wr(A_RS, 32'hFFFF_FFFF, e); chk("t6.rsv_wr.err", 32'(e), 32'd1);
    apb_wr(A_RX, 32'h0000_00FF, e); chk("t6.rx_wr.err", 32'(e), 32'd1);
    apb_rd(32'hFFFF_FFF8, d, e); chk("t6.alias_ctrl", d, 32'h1); chk("t6.alias_err", 32'(e), 32'd0);
`ifdef RX_PARITY_EN
    rx_frame(8'h03, 1'b1, 1'b0);
    apb_rd(A_ST, d, e); chk("t6.pe_status", d, 32'h010);
    w1c_status(32'h10);
    check_status("t6.pe_clr");
`else
    rx_frame(8'h03, 1'b1, 1'b1);
    w1c_status(32'h1C);
    check_status("t6.no_pe");
    check_rxdata("t6.rd");
`endif

    // Disabled receiver ignores the line
    apb_wr(A_CT, 32'h0, e);
    send_frame(8'h99, 1'b1, 1'b1);
    check_status("dis.status");
    apb_wr(A_CT, 32'h1, e);

    // Randomized mix of frames, reads, status checks and clears
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 4));
      if (r <= 1) begin
        b = 8'($urandom);
`ifdef RX_PARITY_EN
        rx_frame(b, $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0);
`else
        rx_frame(b, $urandom_range(0, 5) != 0, 1'b1);
`endif
      end else if (r == 2) begin
        check_rxdata("rnd.rd");
      end else if (r == 3) begin
        check_status("rnd.status");
      end else begin
        w1c_status(32'($urandom_range(0, 7)) << 2);
        check_status("rnd.w1c");
      end
    end
    while (model_q.size() != 0) check_rxdata("drain.rd");
    check_rxdata("drain.empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
